// File: rtl/operand_fetch.sv
// ============================================================================
// Module   : operand_fetch
// Purpose  : Fetches rs1/rs2 operands via a single shared register-file port.
//            Writeback traffic has priority on that port. The optional define
//            OPERAND_FETCH_BYPASS_EN forwards writebacks into operands held in OUT.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module operand_fetch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        instr_ready,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        rf_write,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_wdata,
  input  logic [31:0] rf_rdata,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [31:0] op_a,
  output logic [31:0] op_b
);

  localparam int c_REG_W  = 5;
  localparam int c_DATA_W = 32;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE_A = 3'd1,
    S_ISSUE_B = 3'd2,
    S_CAPT_B  = 3'd3,
    S_OUT     = 3'd4
  } state_t;

  state_t              r_state;
  logic [c_REG_W-1:0]  r_rs1;
  logic [c_REG_W-1:0]  r_rs2;
  logic                r_op_valid;
  logic [c_DATA_W-1:0] r_op_a;
  logic [c_DATA_W-1:0] r_op_b;

  logic w_accept;
  logic w_handshake;
  logic w_wb_live;
  logic w_byp_a;
  logic w_byp_b;

  assign instr_ready = rst_n && (r_state == S_IDLE);
  assign w_accept    = instr_valid && instr_ready;
  assign w_handshake = r_op_valid && op_ready;
  assign w_wb_live   = wb_valid && (wb_addr != '0);

`ifdef OPERAND_FETCH_BYPASS_EN
  assign w_byp_a = w_wb_live && (wb_addr == r_rs1);
  assign w_byp_b = w_wb_live && (wb_addr == r_rs2);
`else
  assign w_byp_a = 1'b0;
  assign w_byp_b = 1'b0;
`endif

  // Writeback owns the port whenever it is requested, even for a dropped r0 write.
  assign rf_write = rst_n && w_wb_live;
  assign rf_wdata = wb_data;

  always_comb begin
    rf_addr = '0;
    if (rst_n) begin
      if (wb_valid)
        rf_addr = wb_addr;
      else if (r_state == S_ISSUE_A)
        rf_addr = r_rs1;
      else if (r_state == S_ISSUE_B)
        rf_addr = r_rs2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_op_valid <= 1'b0;
      r_op_a     <= '0;
      r_op_b     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rs1   <= rs1;
            r_rs2   <= rs2;
            r_state <= S_ISSUE_A;
          end
        end
        S_ISSUE_A: begin
          if (!wb_valid)
            r_state <= S_ISSUE_B;
        end
        S_ISSUE_B: begin
          // rf_rdata still holds the rs1 read while stalled here.
          r_op_a <= (r_rs1 == '0) ? '0 : rf_rdata;
          if (!wb_valid)
            r_state <= S_CAPT_B;
        end
        S_CAPT_B: begin
          r_op_b     <= (r_rs2 == '0) ? '0 : rf_rdata;
          r_op_valid <= 1'b1;
          r_state    <= S_OUT;
        end
        S_OUT: begin
          if (w_byp_a)
            r_op_a <= wb_data;
          if (w_byp_b)
            r_op_b <= wb_data;
          if (w_handshake) begin
            r_op_valid <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_op_valid <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign op_valid = r_op_valid;
  assign op_a     = r_op_a;
  assign op_b     = r_op_b;

endmodule

`default_nettype wire

// File: tb/tb_operand_fetch.sv
// ============================================================================
// Module   : tb_operand_fetch
// Purpose  : Self-checking bench for operand_fetch, with a register-file model
//            and a transaction-level reference. Honours OPERAND_FETCH_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic        instr_ready;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        rf_write;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata;
  logic [31:0] rf_rdata = '0;
  logic        op_valid;
  logic        op_ready = 1'b0;
  logic [31:0] op_a;
  logic [31:0] op_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .rs1         (rs1),
    .rs2         (rs2),
    .instr_ready (instr_ready),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .rf_write    (rf_write),
    .rf_addr     (rf_addr),
    .rf_wdata    (rf_wdata),
    .rf_rdata    (rf_rdata),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_a        (op_a),
    .op_b        (op_b)
  );

  // Register file: a read is any edge with no writeback request on the port.
  logic [31:0] rf_mem [32];
  always @(posedge clk) begin
    if (rf_write)
      rf_mem[rf_addr] <= rf_wdata;
    else if (!wb_valid)
      rf_rdata <= rf_mem[rf_addr];
  end

  // Reference: architectural register contents plus transaction progress.
  logic [31:0] ref_regs [32];
  int          m_mode = 0;   // 0 idle, 1 fetching, 2 capturing, 3 presenting
  int          m_reads = 0;
  logic [4:0]  m_rs1 = '0;
  logic [4:0]  m_rs2 = '0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  logic        m_valid = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] reg_val(input logic [4:0] r);
    return (r == 5'd0) ? 32'h0 : ref_regs[r];
  endfunction

  // Advance the reference across one rising edge using the inputs now applied.
  task automatic model_edge();
    if (!rst_n) begin
      m_mode  = 0;
      m_valid = 1'b0;
      m_a     = '0;
      m_b     = '0;
      return;
    end
    case (m_mode)
      0: if (instr_valid) begin
        m_rs1 = rs1; m_rs2 = rs2; m_reads = 0; m_mode = 1;
      end
      1: if (!wb_valid) begin
        m_reads++;
        if (m_reads == 1) m_a = reg_val(m_rs1);
        else begin m_b = reg_val(m_rs2); m_mode = 2; end
      end
      2: begin m_mode = 3; m_valid = 1'b1; end
      default: begin
`ifdef OPERAND_FETCH_BYPASS_EN
        if (wb_valid && wb_addr != 0 && wb_addr == m_rs1) m_a = wb_data;
        if (wb_valid && wb_addr != 0 && wb_addr == m_rs2) m_b = wb_data;
`endif
        if (op_ready) begin m_valid = 1'b0; m_mode = 0; end
      end
    endcase
    if (wb_valid && wb_addr != 0) ref_regs[wb_addr] = wb_data;
  endtask

  // Called at a falling edge after inputs are set; returns at the next falling edge.
  task automatic step();
    #1;
    check_eq("rf_write", {31'd0, rf_write}, {31'd0, rst_n && wb_valid && (wb_addr != 0)});
    if (rst_n && wb_valid) check_eq("rf_addr_wb", {27'd0, rf_addr}, {27'd0, wb_addr});
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_eq("instr_ready", {31'd0, instr_ready}, {31'd0, rst_n && (m_mode == 0)});
    check_eq("op_valid", {31'd0, op_valid}, {31'd0, m_valid});
    if (m_valid) begin
      check_eq("op_a", op_a, m_a);
      check_eq("op_b", op_b, m_b);
    end
  endtask

  task automatic quiet();
    instr_valid = 1'b0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
  endtask

  task automatic issue(input logic [4:0] a, input logic [4:0] b);
    instr_valid = 1'b1; rs1 = a; rs2 = b;
    step();
    instr_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      logic [31:0] v;
      v = $urandom;
      rf_mem[i] = v;
      ref_regs[i] = v;
    end
    rf_mem[0] = 32'hFFFFFFFF;
    rf_mem[5] = 32'h11111111; ref_regs[5] = 32'h11111111;
    rf_mem[9] = 32'h22222222; ref_regs[9] = 32'h22222222;

    // Reset: outputs forced regardless of a live writeback request.
    @(negedge clk);
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'h0BAD0BAD;
    #1;
    check_eq("rst_rf_write", {31'd0, rf_write}, 32'd0);
    check_eq("rst_rf_addr", {27'd0, rf_addr}, 32'd0);
    check_eq("rst_instr_ready", {31'd0, instr_ready}, 32'd0);
    check_eq("rst_op_valid", {31'd0, op_valid}, 32'd0);
    check_eq("rst_op_a", op_a, 32'd0);
    check_eq("rst_op_b", op_b, 32'd0);
    step();
    quiet();
    rst_n = 1'b1;
    op_ready = 1'b1;

    // Basic fetch: op_valid exactly after the third edge past acceptance.
    issue(5'd5, 5'd9);
    step(); step();
    check_eq("s1_not_early", {31'd0, op_valid}, 32'd0);
    step();
    check_eq("s1_op_a", op_a, 32'h11111111);
    check_eq("s1_op_b", op_b, 32'h22222222);
    step();

    // Zero register plus a dropped r0 writeback that still stalls.
    issue(5'd0, 5'd5);
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'h0000DEAD;
    step();
    quiet();
    step(); step();
    check_eq("s2_stall_delay", {31'd0, op_valid}, 32'd0);
    step();
    check_eq("s2_op_a_zero", op_a, 32'd0);
    check_eq("s2_op_b", op_b, 32'h11111111);
    step();

    // Writeback stall in ISSUE_A, then backpressure for 10 cycles.
    op_ready = 1'b0;
    issue(5'd5, 5'd9);
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hABCD0001;
    step(); step();
    quiet();
    step(); step();
    check_eq("s3_not_early", {31'd0, op_valid}, 32'd0);
    step();
    check_eq("s3_op_a", op_a, 32'hABCD0001);
    for (int i = 0; i < 10; i++) step();
    check_eq("s4_held_a", op_a, 32'hABCD0001);
    check_eq("s4_held_b", op_b, 32'h22222222);
    op_ready = 1'b1;
    step();
    check_eq("s4_idle", {31'd0, instr_ready}, 32'd1);

    // Reset asserted in CAPT_B.
    issue(5'd5, 5'd9);
    step(); step();
    rst_n = 1'b0;
    #1;
    check_eq("s5_op_valid", {31'd0, op_valid}, 32'd0);
    check_eq("s5_op_a", op_a, 32'd0);
    check_eq("s5_instr_ready", {31'd0, instr_ready}, 32'd0);
    step();
    rst_n = 1'b1;
    step(); step(); step();

    // Writeback to rs2 while operands are held in OUT.
    op_ready = 1'b0;
    issue(5'd5, 5'd9);
    step(); step(); step();
    wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h5A5A5A5A;
    step();
    quiet();
`ifdef OPERAND_FETCH_BYPASS_EN
    check_eq("s6_op_b", op_b, 32'h5A5A5A5A);
`else
    check_eq("s6_op_b", op_b, 32'h22222222);
`endif
    op_ready = 1'b1;
    step();

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      instr_valid = $urandom_range(0, 1) == 1;
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      wb_valid = $urandom_range(0, 9) < 3;
      wb_addr = 5'($urandom_range(0, 7));
      wb_data = $urandom;
      op_ready = $urandom_range(0, 2) != 0;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
